// File: rtl/video_timing_ctrl_if.sv
// Pixel-path bundle between the raster scheduler, the shader and the TMDS encoder.
// The master side is the scheduler. The slave side is the shader/encoder, or a bench.
interface video_timing_ctrl_if;
    logic        i_enable;
    logic        o_busy;
    logic        o_req;
    logic [11:0] o_req_x;
    logic [11:0] o_req_y;
    logic        o_newline;
    logic        o_newframe;
    logic [23:0] i_pixel;
    logic        o_de;
    logic        o_hsync;
    logic        o_vsync;
    logic [23:0] o_pixel;

    modport master (
        input  i_enable, i_pixel,
        output o_busy, o_req, o_req_x, o_req_y, o_newline, o_newframe,
        output o_de, o_hsync, o_vsync, o_pixel
    );

    modport slave (
        output i_enable, i_pixel,
        input  o_busy, o_req, o_req_x, o_req_y, o_newline, o_newframe,
        input  o_de, o_hsync, o_vsync, o_pixel
    );
endinterface

// File: rtl/video_timing_ctrl.sv
// Raster scheduler: issues shader coordinate requests, then realigns the returned pixel
// with delayed sync and data enable. The raster starts and stops only on frame boundaries.
module video_timing_ctrl #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned LATENCY   = 2
) (
    input logic                i_pixclk,
    input logic                i_reset,
    video_timing_ctrl_if.master vif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [11:0] HLast   = 12'(H_TOTAL - 1);
    localparam logic [11:0] VLast   = 12'(V_TOTAL - 1);

    typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

    state_e              state_q;
    logic [11:0]         hpos_q, vpos_q;
    logic                req_q, hs_q, vs_q, newline_q, newframe_q;
    logic [LATENCY-1:0]  de_dly_q, hs_dly_q, vs_dly_q;
    logic                de_q, hs_out_q, vs_out_q;
    logic [23:0]         pixel_q;

    logic                last_px, present;
    logic [11:0]         h_inc, v_inc, h_d, v_d;
    logic                req_d, hs_d, vs_d, newline_d, newframe_d;

    // hpos_q/vpos_q hold the position currently shown at the request stage.
    always_comb begin
        last_px = (hpos_q == HLast) && (vpos_q == VLast);
        h_inc   = (hpos_q == HLast) ? 12'd0 : hpos_q + 12'd1;
        if (hpos_q != HLast) begin
            v_inc = vpos_q;
        end else begin
            v_inc = (vpos_q == VLast) ? 12'd0 : vpos_q + 12'd1;
        end

        present = 1'b0;
        h_d     = 12'd0;
        v_d     = 12'd0;
        unique case (state_q)
            StIdle: begin
                present = vif.i_enable;
            end
            default: begin
                present = !(last_px && !vif.i_enable);
                h_d     = present ? h_inc : 12'd0;
                v_d     = present ? v_inc : 12'd0;
            end
        endcase

        req_d      = present && (32'(h_d) < H_ACTIVE) && (32'(v_d) < V_ACTIVE);
        hs_d       = present && (32'(h_d) >= H_ACTIVE + H_FRONT)
                             && (32'(h_d) <  H_ACTIVE + H_FRONT + H_SYNC);
        vs_d       = present && (32'(v_d) >= V_ACTIVE + V_FRONT)
                             && (32'(v_d) <  V_ACTIVE + V_FRONT + V_SYNC);
        newline_d  = present && (h_d == 12'd0);
        newframe_d = present && (h_d == 12'd0) && (v_d == 12'd0);
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            hpos_q     <= '0;
            vpos_q     <= '0;
            req_q      <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            newline_q  <= 1'b0;
            newframe_q <= 1'b0;
            de_dly_q   <= '0;
            hs_dly_q   <= '0;
            vs_dly_q   <= '0;
            de_q       <= 1'b0;
            hs_out_q   <= 1'b0;
            vs_out_q   <= 1'b0;
            pixel_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle:     if (vif.i_enable) state_q <= StRun;
                StRun:      if (!vif.i_enable) state_q <= last_px ? StIdle : StStopping;
                StStopping: begin
                    if (vif.i_enable)  state_q <= StRun;
                    else if (last_px)  state_q <= StIdle;
                end
                default:    state_q <= StIdle;
            endcase

            hpos_q     <= h_d;
            vpos_q     <= v_d;
            req_q      <= req_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            newline_q  <= newline_d;
            newframe_q <= newframe_d;

            // Delay line matches the shader latency; the output register adds one more stage.
            de_dly_q[0] <= req_q;
            hs_dly_q[0] <= hs_q;
            vs_dly_q[0] <= vs_q;
            for (int i = 1; i < LATENCY; i++) begin
                de_dly_q[i] <= de_dly_q[i-1];
                hs_dly_q[i] <= hs_dly_q[i-1];
                vs_dly_q[i] <= vs_dly_q[i-1];
            end

            de_q     <= de_dly_q[LATENCY-1];
            hs_out_q <= hs_dly_q[LATENCY-1];
            vs_out_q <= vs_dly_q[LATENCY-1];
            pixel_q  <= de_dly_q[LATENCY-1] ? vif.i_pixel : 24'd0;
        end
    end

    assign vif.o_busy     = (state_q != StIdle);
    assign vif.o_req      = req_q;
    assign vif.o_req_x    = hpos_q;
    assign vif.o_req_y    = vpos_q;
    assign vif.o_newline  = newline_q;
    assign vif.o_newframe = newframe_q;
    assign vif.o_de       = de_q;
    assign vif.o_hsync    = hs_out_q ? HSYNC_POL : ~HSYNC_POL;
    assign vif.o_vsync    = vs_out_q ? VSYNC_POL : ~VSYNC_POL;
    assign vif.o_pixel    = pixel_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Randomized enable/reset stimulus against a frame-index reference model of the raster.
// A small raster keeps whole frames short.
module tb_video_timing_ctrl;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int LAT = 3;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    typedef struct packed {
        logic        busy, req, nl, nf, hs, vs;
        logic [11:0] x, y;
    } rq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    video_timing_ctrl_if vif ();

    video_timing_ctrl #(
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .LATENCY(LAT)
    ) dut (
        .i_pixclk(clk),
        .i_reset (rst),
        .vif     (vif)
    );

    always #5 clk = ~clk;

    rq_t         hist[64];
    logic [23:0] pix_hist[64];
    int          n = 0;
    bit          running = 1'b0;
    int          k = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic rq_t idle_rq();
        rq_t r = '0;
        return r;
    endfunction

    // Request-stage values for a frame-linear index kk = y*HT + x.
    function automatic rq_t pos_rq(input int kk);
        rq_t r;
        int  x, y;
        x      = kk % HT;
        y      = kk / HT;
        r.busy = 1'b1;
        r.req  = (x < HA) && (y < VA);
        r.nl   = (x == 0);
        r.nf   = (kk == 0);
        r.hs   = (x >= HA + HF) && (x < HA + HF + HS);
        r.vs   = (y >= VA + VF) && (y < VA + VF + VS);
        r.x    = 12'(x);
        r.y    = 12'(y);
        return r;
    endfunction

    task automatic step(input bit en, input bit rs);
        rq_t         r, o, src;
        logic [23:0] p;
        logic        eh, ev;
        vif.i_enable = en;
        rst          = rs;
        // Model shader: coordinate pattern for live requests, noise otherwise.
        src = hist[(n - LAT) & 63];
        p   = src.req ? {src.x[7:0], src.y[7:0], 8'hA5} : 24'($urandom);
        vif.i_pixel      = p;
        pix_hist[n & 63] = p;
        @(posedge clk);
        #1;
        n++;
        if (rs) begin
            running = 1'b0;
            k       = 0;
            for (int m = 0; m <= LAT + 1; m++) hist[(n - m) & 63] = idle_rq();
        end else if (!running) begin
            if (en) begin
                running = 1'b1;
                k       = 0;
            end
        end else if (k == FR - 1 && !en) begin
            running = 1'b0;
            k       = 0;
        end else begin
            k = (k + 1) % FR;
        end
        r = running ? pos_rq(k) : idle_rq();
        hist[n & 63] = r;

        check_eq("busy",     32'(vif.o_busy),     32'(r.busy));
        check_eq("req",      32'(vif.o_req),      32'(r.req));
        check_eq("req_x",    32'(vif.o_req_x),    32'(r.x));
        check_eq("req_y",    32'(vif.o_req_y),    32'(r.y));
        check_eq("newline",  32'(vif.o_newline),  32'(r.nl));
        check_eq("newframe", 32'(vif.o_newframe), 32'(r.nf));

        o  = hist[(n - LAT - 1) & 63];
        eh = o.hs ? HPOL : ~HPOL;
        ev = o.vs ? VPOL : ~VPOL;
        check_eq("de",    32'(vif.o_de),    32'(o.req));
        check_eq("hsync", 32'(vif.o_hsync), 32'(eh));
        check_eq("vsync", 32'(vif.o_vsync), 32'(ev));
        check_eq("pixel", 32'(vif.o_pixel), o.req ? 32'(pix_hist[(n - 1) & 63]) : 32'd0);
    endtask

    initial begin
        bit en;
        for (int m = 0; m < 64; m++) begin
            hist[m]     = '0;
            pix_hist[m] = '0;
        end
        vif.i_enable = 1'b0;
        vif.i_pixel  = '0;

        repeat (3) step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        repeat (2 * FR + 3 * HT) step(1'b1, 1'b0);
        // Drop mid-frame; the frame completes and the raster idles.
        repeat (FR + 10) step(1'b0, 1'b0);
        repeat (40) step(1'b1, 1'b0);
        // Re-assert during the stopping phase.
        repeat (20) step(1'b0, 1'b0);
        repeat (FR) step(1'b1, 1'b0);
        // Enable falls exactly on the last pixel of the frame.
        for (int i = 0; i < FR + 5 && !(running && k == FR - 1); i++) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        // Reset mid-frame while the pipeline holds live data.
        repeat (4 * HT + 5) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (LAT + 4) step(1'b0, 1'b0);
        repeat (60) step(1'b1, 1'b0);

        en = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(99) == 0) en = !en;
            step(en, $urandom_range(499) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
